// File: rtl/fp_sub_result_stage.sv
// fp_sub_result_stage
//   Result buffer behind the combinational floating-point subtractor. Each
//   accepted IEEE-754 single word is classified into {nan, inf, zero, denorm}.
//   The word and its flags are then stored in a small FIFO, which is presented
//   to the consumer with a valid/ready handshake. The stage also keeps sticky
//   flags and a saturating count of completed (popped) results.
//
// Parameters
//   DEPTH  buffer entries, a power of two and at least 2
//   CNT_W  width of done_count
//
// Ports
//   clk           clock, rising-edge
//   n_rst         asynchronous active-low reset
//   in_valid      sub_result is valid this cycle
//   sub_result    32-bit result word from the subtractor
//   in_ready      buffer has a free entry
//   out_valid     out_result/out_flags hold the head entry
//   out_ready     consumer takes the head entry this cycle
//   out_result    head entry result word
//   out_flags     head entry flags {nan, inf, zero, denorm}
//   sticky_flags  OR of flags of every push since the last clear
//   flag_clr      synchronous clear of sticky_flags
//   done_count    number of pops, saturating at all-ones
module fp_sub_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic [31:0]      sub_result,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       sticky_flags,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] done_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             push;
  logic             pop;
  logic [3:0]       flags_p0;

  logic [31:0] data_p1  [DEPTH];
  logic [3:0]  flags_p1 [DEPTH];

  // Exactly one class bit is set for a special value; normal numbers give 0000.
  function automatic logic [3:0] classify(input logic [31:0] w);
    logic exp_ones;
    logic exp_zero;
    logic man_nz;
    exp_ones = &w[30:23];
    exp_zero = ~|w[30:23];
    man_nz   = |w[22:0];
    return {exp_ones & man_nz, exp_ones & ~man_nz,
            exp_zero & ~man_nz, exp_zero & man_nz};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Handshake status depends only on occupancy, never on out_ready or in_valid.
  assign in_ready  = (occ != DEPTH_C);
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign flags_p0  = classify(sub_result);

  // ---- stage p0 -> p1: classify and write into the buffer ----
  always_ff @(posedge clk) begin
    if (push) begin
      data_p1[wr_ptr]  <= sub_result;
      flags_p1[wr_ptr] <= flags_p0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      sticky_flags <= '0;
      done_count   <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
      // A clear in the same cycle as a push keeps that push's flags.
      if (push)          sticky_flags <= (flag_clr ? 4'b0000 : sticky_flags) | flags_p0;
      else if (flag_clr) sticky_flags <= 4'b0000;
      if (pop) done_count <= sat_inc(done_count);
    end
  end

  // ---- stage p1: head entry; empty slots read as zero so reset shows 0 ----
  assign out_result = out_valid ? data_p1[rd_ptr]  : 32'h0;
  assign out_flags  = out_valid ? flags_p1[rd_ptr] : 4'h0;

endmodule

// File: tb/tb_fp_sub_result_stage.sv
module tb_fp_sub_result_stage;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid, out_ready, flag_clr;
  logic [31:0] sub_result;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_flags, sticky_flags;
  logic [15:0] done_count;

  logic        in4_valid, out4_ready, flag4_clr;
  logic [31:0] sub4_result;
  logic        in4_ready, out4_valid;
  logic [31:0] out4_result;
  logic [3:0]  out4_flags, sticky4_flags;
  logic [3:0]  done4_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_sub_result_stage dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .sub_result(sub_result),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .sticky_flags(sticky_flags),
    .flag_clr(flag_clr), .done_count(done_count)
  );

  fp_sub_result_stage #(.DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in4_valid), .sub_result(sub4_result),
    .in_ready(in4_ready), .out_valid(out4_valid), .out_ready(out4_ready),
    .out_result(out4_result), .out_flags(out4_flags), .sticky_flags(sticky4_flags),
    .flag_clr(flag4_clr), .done_count(done4_count)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
    in_valid = v; sub_result = d; out_ready = r; flag_clr = c;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    in4_valid = 1'b0; sub4_result = 32'h0; out4_ready = 1'b0; flag4_clr = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL rst_out_result: got %h want 0", out_result); end
    n_cmp++; if (out_flags !== 4'h0) begin n_fail++; $display("FAIL rst_out_flags: got %b want 0000", out_flags); end
    n_cmp++; if (sticky_flags !== 4'h0) begin n_fail++; $display("FAIL rst_sticky: got %b want 0000", sticky_flags); end
    n_cmp++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL rst_done: got %0d want 0", done_count); end
    n_rst = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 32'h3FCCCCCD, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'h3FCCCCCD) begin n_fail++; $display("FAIL single_result: got %h want 3fcccccd", out_result); end
    n_cmp++; if (out_flags !== 4'b0000) begin n_fail++; $display("FAIL single_flags: got %b want 0000", out_flags); end
    n_cmp++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL single_done0: got %0d want 0", done_count); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (done_count !== 16'd1) begin n_fail++; $display("FAIL single_done1: got %0d want 1", done_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_full();
    drive(1'b1, 32'h7F800000, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1: got %b want 1", in_ready); end
    drive(1'b1, 32'h7FC00000, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready0: got %b want 0", in_ready); end
    // Third push offered while full must be ignored.
    drive(1'b1, 32'h80000000, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %b want 0", in_ready); end
    n_cmp++; if (out_result !== 32'h7F800000) begin n_fail++; $display("FAIL full_head0: got %h want 7f800000", out_result); end
    n_cmp++; if (out_flags !== 4'b0100) begin n_fail++; $display("FAIL full_flags0: got %b want 0100", out_flags); end
    // Pop while full: occupancy drops to 1, push still blocked this edge.
    drive(1'b1, 32'h80000000, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_afterpop: got %b want 1", in_ready); end
    n_cmp++; if (out_result !== 32'h7FC00000) begin n_fail++; $display("FAIL full_head1: got %h want 7fc00000", out_result); end
    n_cmp++; if (out_flags !== 4'b1000) begin n_fail++; $display("FAIL full_flags1: got %b want 1000", out_flags); end
    @(negedge clk);
    n_cmp++; if (out_result !== 32'h80000000) begin n_fail++; $display("FAIL full_head2: got %h want 80000000", out_result); end
    n_cmp++; if (out_flags !== 4'b0010) begin n_fail++; $display("FAIL full_flags2: got %b want 0010", out_flags); end
    drive(1'b1, 32'h00000001, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_result !== 32'h00000001) begin n_fail++; $display("FAIL full_head3: got %h want 00000001", out_result); end
    n_cmp++; if (out_flags !== 4'b0001) begin n_fail++; $display("FAIL full_flags3: got %b want 0001", out_flags); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", out_valid); end
    n_cmp++; if (done_count !== 16'd5) begin n_fail++; $display("FAIL full_done: got %0d want 5", done_count); end
    // out_ready on an empty buffer changes nothing.
    @(negedge clk);
    n_cmp++; if (done_count !== 16'd5) begin n_fail++; $display("FAIL empty_pop: got %0d want 5", done_count); end
  endtask

  task automatic test_sticky();
    n_cmp++; if (sticky_flags !== 4'b1111) begin n_fail++; $display("FAIL sticky_all: got %b want 1111", sticky_flags); end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL sticky_clr: got %b want 0000", sticky_flags); end
    // Fill sticky again, then clear together with a denorm push.
    drive(1'b1, 32'h7F800000, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h00000001, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (sticky_flags !== 4'b0001) begin n_fail++; $display("FAIL sticky_clr_push: got %b want 0001", sticky_flags); end
    drive(1'b1, 32'h3F800000, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (sticky_flags !== 4'b0001) begin n_fail++; $display("FAIL sticky_normal: got %b want 0001", sticky_flags); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (done_count !== 16'd8) begin n_fail++; $display("FAIL sticky_done: got %0d want 8", done_count); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h40000000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hC3BEB333, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_result !== 32'hC3BEB333) begin n_fail++; $display("FAIL b2b_head: got %h want c3beb333", out_result); end
    n_cmp++; if (out_flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_flags: got %b want 0000", out_flags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_occ1: got %b want 0", out_valid); end
    n_cmp++; if (done_count !== 16'd10) begin n_fail++; $display("FAIL b2b_done: got %0d want 10", done_count); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h22222222, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_full: got %b want 0", in_ready); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", in_ready); end
    n_cmp++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL ar_done: got %0d want 0", done_count); end
    n_cmp++; if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL ar_sticky: got %b want 0000", sticky_flags); end
    @(negedge clk);
    n_rst = 1'b1;
    drive(1'b1, 32'h33333333, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_result !== 32'h33333333) begin n_fail++; $display("FAIL ar_first_push: got %h want 33333333", out_result); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    in4_valid = 1'b1; sub4_result = 32'h3F800000; out4_ready = 1'b1;
    // One push-only edge, then a push and a pop on every edge.
    repeat (10) @(negedge clk);
    n_cmp++; if (done4_count !== 4'd9) begin n_fail++; $display("FAIL sat_mid: got %0d want 9", done4_count); end
    repeat (6) @(negedge clk);
    n_cmp++; if (done4_count !== 4'd15) begin n_fail++; $display("FAIL sat_max: got %0d want 15", done4_count); end
    repeat (4) @(negedge clk);
    n_cmp++; if (done4_count !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", done4_count); end
    in4_valid = 1'b0; out4_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_sticky();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
